// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 transmitter. Sends one command byte to
//                the keyboard with the request-to-send handshake: hold the
//                clock low, drive the start bit, release the clock, shift the
//                data and odd parity on the device's falling clock edges,
//                release the line for the stop bit, then check the ack.
//                The PS/2 lines are open-collector, so this block only drives
//                output enables (1 = pull the line low).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock50     in   system clock, all logic on the rising edge
//    rst_n       in   asynchronous active-low reset
//    tx_data     in   byte to send, sampled with an accepted tx_start
//    tx_start    in   one-cycle request strobe (ignored while busy)
//    tx_busy     out  high from the accepted request until back in IDLE
//    tx_done     out  one-cycle pulse: frame sent and ack seen
//    tx_error    out  one-cycle pulse: timeout or missing ack
//    ps2_clk_in  in   raw PS/2 clock line (asynchronous)
//    ps2_dat_in  in   raw PS/2 data line (asynchronous)
//    ps2_clk_oe  out  1 = pull PS/2 clock low
//    ps2_dat_oe  out  1 = pull PS/2 data low
// ============================================================================
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       clock50,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_BITS      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning. Everything resets to 1 so an idle bus never
    // looks like a falling edge coming out of reset.
    // ------------------------------------------------------------------
    logic             clk_s1_q;
    logic             clk_s2_q;
    logic             dat_s1_q;
    logic             dat_s2_q;
    logic             clk_filt_q;
    logic             clk_filt_prev_q;
    logic [FLT_W-1:0] flt_cnt_q;
    logic             clk_fe;

    always_ff @(posedge clock50 or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q        <= 1'b1;
            clk_s2_q        <= 1'b1;
            dat_s1_q        <= 1'b1;
            dat_s2_q        <= 1'b1;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
            flt_cnt_q       <= '0;
        end else begin
            clk_s1_q        <= ps2_clk_in;
            clk_s2_q        <= clk_s1_q;
            dat_s1_q        <= ps2_dat_in;
            dat_s2_q        <= dat_s1_q;
            clk_filt_prev_q <= clk_filt_q;
            // The synchronized clock must disagree with the accepted level
            // for FILTER_LEN consecutive cycles before the new level is
            // taken; any return to the old level restarts the count, which
            // rejects short glitches on the line.
            if (clk_s2_q == clk_filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt_q <= clk_s2_q;
                flt_cnt_q  <= '0;
            end else begin
                flt_cnt_q <= flt_cnt_q + 1'b1;
            end
        end
    end

    // One-cycle pulse on a filtered 1 -> 0 transition.
    assign clk_fe = clk_filt_prev_q & ~clk_filt_q;

    // ------------------------------------------------------------------
    // Transmit sequencer with registered outputs.
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [9:0]       shift_q;     // {stop, parity, data[7:0]}, LSB sent first
    logic [3:0]       bit_cnt_q;
    logic [INH_W-1:0] inh_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             ack_ok_q;

    always_ff @(posedge clock50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ack_ok_q   <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    if (tx_start) begin
                        // Reduction XNOR gives odd parity over data+parity.
                        shift_q    <= {1'b1, ~^tx_data, tx_data};
                        bit_cnt_q  <= '0;
                        inh_cnt_q  <= '0;
                        ack_ok_q   <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        tx_busy    <= 1'b1;
                        state_q    <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    ps2_clk_oe <= 1'b1;
                    ps2_dat_oe <= 1'b0;
                    // The clock was already pulled low on the accept edge,
                    // so the last inhibit cycle is counter value N-1.
                    if (inh_cnt_q >= INH_W'(INHIBIT_CYCLES - 1)) begin
                        ps2_dat_oe <= 1'b1;
                        state_q    <= ST_START;
                    end else begin
                        inh_cnt_q <= inh_cnt_q + 1'b1;
                    end
                end

                ST_START: begin
                    // Start bit stays driven; releasing the clock hands
                    // clocking over to the device.
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b1;
                    to_cnt_q   <= '0;
                    state_q    <= ST_BITS;
                end

                ST_BITS, ST_ACK, ST_WAIT_IDLE: begin
                    if (to_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        tx_busy    <= 1'b0;
                        tx_error   <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        if (to_cnt_q < TO_W'(TIMEOUT_CYCLES)) begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end

                        if (state_q == ST_BITS) begin
                            if (clk_fe) begin
                                // Open collector: drive low for a 0 bit,
                                // release for a 1 bit (including stop).
                                ps2_dat_oe <= ~shift_q[0];
                                shift_q    <= {1'b0, shift_q[9:1]};
                                bit_cnt_q  <= bit_cnt_q + 1'b1;
                                if (bit_cnt_q == 4'd9) begin
                                    state_q <= ST_ACK;
                                end
                            end
                        end else if (state_q == ST_ACK) begin
                            ps2_dat_oe <= 1'b0;
                            if (clk_fe) begin
                                ack_ok_q <= ~dat_s2_q;
                                state_q  <= ST_WAIT_IDLE;
                            end
                        end else begin
                            ps2_dat_oe <= 1'b0;
                            // Finish only once the device has let go of
                            // both lines, so the receive path sees an idle
                            // bus afterwards.
                            if (clk_filt_q && dat_s2_q) begin
                                tx_busy  <= 1'b0;
                                tx_done  <= ack_ok_q;
                                tx_error <= ~ack_ok_q;
                                state_q  <= ST_IDLE;
                            end
                        end
                    end
                end

                default: begin
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    tx_busy    <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Bench for ps2_host_tx with a behavioural PS/2 device that
//                generates the clock after a request-to-send, records the
//                data line before each falling edge and optionally acks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 60;
    localparam int TO   = 2500;
    localparam int FLT  = 8;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       glitch_low = 1'b0;
    wire        ps2_clk_in = ~(ps2_clk_oe | dev_clk_low | glitch_low);
    wire        ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FLT)
    ) u_dut (
        .clock50   (clk),
        .rst_n     (rst_n),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    always #10 clk = ~clk;

    // Each cycle a pulse is high counts once, so a stretched pulse shows up.
    always @(negedge clk) begin
        if (tx_done)             done_cnt++;
        if (tx_error)            err_cnt++;
        if (tx_done && tx_error) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference frame as seen on the wire, index 0 first:
    // start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        int   ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
        par = ((ones % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    // Issue a request and check the inhibit / start-bit / release timing.
    task automatic start_tx(input logic [7:0] d);
        int j;
        int first_dat;
        int first_rel;
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        check_eq("clk_oe_rise", ps2_clk_oe, 1);
        check_eq("busy_rise", tx_busy, 1);
        j = 1;
        first_dat = 0;
        first_rel = 0;
        while (first_rel == 0 && j < INH + 20) begin
            @(negedge clk);
            j++;
            if (ps2_dat_oe && first_dat == 0) first_dat = j;
            if (!ps2_clk_oe) first_rel = j;
        end
        check_eq("dat_oe_lat", first_dat, INH + 1);
        check_eq("clk_rel_lat", first_rel, INH + 2);
    endtask

    // Device model: 11 clock pulses, line sampled just before each fall.
    task automatic device(input logic [7:0] d, input bit ack, input int rst_at,
                          input int glitch_at, output logic [10:0] fr,
                          output bit aborted, output int busy_low);
        aborted  = 1'b0;
        busy_low = 0;
        fr       = '0;
        repeat (30) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            fr[k-1] = ps2_dat_in;
            if (!tx_busy) busy_low++;
            dev_clk_low = 1'b1;
            if (k == 11 && ack) dev_dat_low = 1'b1;
            if (k == rst_at) begin
                repeat (14) @(negedge clk);
                check_eq("pre_rst_dat_oe", ps2_dat_oe, 1);
                rst_n = 1'b0;
                #1;
                check_eq("rst_clk_oe", ps2_clk_oe, 0);
                check_eq("rst_dat_oe", ps2_dat_oe, 0);
                check_eq("rst_busy", tx_busy, 0);
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                repeat (2) @(negedge clk);
                rst_n   = 1'b1;
                aborted = 1'b1;
                break;
            end
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
            if (k == glitch_at) begin
                repeat (15) @(negedge clk);
                glitch_low = 1'b1;
                tx_start   = 1'b1;
                tx_data    = ~d;
                @(negedge clk);
                tx_start = 1'b0;
                @(negedge clk);
                glitch_low = 1'b0;
                repeat (HALF - 17) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ack, input int rst_at,
                              input int glitch_at);
        int          d0;
        int          e0;
        int          bl;
        logic [10:0] fr;
        bit          ab;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        device(d, ack, rst_at, glitch_at, fr, ab, bl);
        if (ab) begin
            repeat (10) @(negedge clk);
            check_eq("rst_no_done", done_cnt - d0, 0);
            check_eq("rst_no_err", err_cnt - e0, 0);
            check_eq("rst_idle_busy", tx_busy, 0);
        end else begin
            for (int i = 0; i < 200 && tx_busy; i++) @(negedge clk);
            repeat (2) @(negedge clk);
            check_eq("busy_fall", tx_busy, 0);
            check_eq("frame", fr, exp_frame(d));
            check_eq("busy_span", bl, 0);
            check_eq("done_pulses", done_cnt - d0, ack ? 1 : 0);
            check_eq("err_pulses", err_cnt - e0, ack ? 0 : 1);
            check_eq("oe_idle", {ps2_clk_oe, ps2_dat_oe}, 0);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic timeout_test();
        int n;
        int d0;
        int e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA7);
        n = 0;
        while (!tx_error && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_lat", (n >= TO && n <= TO + 2), 1);
        check_eq("timeout_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
        check_eq("timeout_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        check_eq("timeout_err", err_cnt - e0, 1);
        check_eq("timeout_done", done_cnt - d0, 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'hED, 1'b1, 0, 0);
        send_frame(8'hF4, 1'b1, 0, 0);
        send_frame(8'h01, 1'b1, 0, 0);
        send_frame(8'h00, 1'b1, 0, 0);
        send_frame(8'hFF, 1'b1, 0, 0);
        send_frame(8'h5A, 1'b0, 0, 0);   // device withholds the ack
        timeout_test();                  // device never clocks
        send_frame(8'h3C, 1'b1, 0, 4);   // second request + clock glitch
        send_frame(8'h25, 1'b1, 5, 0);   // reset at the fifth falling edge
        for (int r = 0; r < 5; r++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) != 0), 0, 0);
        end

        check_eq("no_overlap", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
